// File: rtl/wb_arb_pkg.sv
// Shared constants for the WISHBONE master arbiter: cycle-type/burst-type codes
// and the arbiter state encoding.
package wb_arb_pkg;

  localparam logic [2:0] WBCTI_CLASSIC = 3'b000;
  localparam logic [2:0] WBCTI_CONST   = 3'b001;
  localparam logic [2:0] WBCTI_INCR    = 3'b010;
  localparam logic [2:0] WBCTI_EOB     = 3'b111;

  localparam logic [1:0] WBBTE_LINEAR  = 2'b00;
  localparam logic [1:0] WBBTE_WRAP4   = 2'b01;
  localparam logic [1:0] WBBTE_WRAP8   = 2'b10;
  localparam logic [1:0] WBBTE_WRAP16  = 2'b11;

  localparam logic WBARB_IDLE = 1'b0;
  localparam logic WBARB_OWN  = 1'b1;

  typedef enum logic {
    ST_IDLE = WBARB_IDLE,
    ST_OWN  = WBARB_OWN
  } arb_state_e;

endpackage

// File: rtl/wb_arb_if.sv
// Bus bundle between NM WISHBONE masters, the arbiter and the bridge slave port.
// Signal suffixes are from the arbiter's point of view (modport slave).
interface wb_arb_if #(parameter int NM = 4);

  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*32-1:0] m_adr_i;
  logic [NM*32-1:0] m_dat_i;
  logic [NM*4-1:0]  m_sel_i;
  logic [NM*3-1:0]  m_cti_i;
  logic [NM*2-1:0]  m_bte_i;
  logic [31:0]      m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;

  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [3:0]       s_sel_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

endinterface

// File: rtl/wb_arb_rr.sv
// Combinational round-robin picker: first requester strictly after 'last'
// in cyclic order wins; the one at 'last' itself is checked last.
module wb_arb_rr
  import wb_arb_pkg::*;
#(
  parameter int NM = 4,
  parameter int LW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] win,
  output logic [LW-1:0] win_idx
);

  logic [LW-1:0] idx_s;
  logic          hit_s;
  logic          found_s;

  // Scan NM candidates starting at last+1, keeping only the first hit
  always_comb begin
    win     = {NM{1'b0}};
    win_idx = {LW{1'b0}};
    idx_s   = {LW{1'b0}};
    hit_s   = 1'b0;
    found_s = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      idx_s      = LW'((int'(last) + i) % NM);
      hit_s      = req[idx_s] & ~found_s;
      win[idx_s] = win[idx_s] | hit_s;
      win_idx    = hit_s ? idx_s : win_idx;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Round-robin arbiter sharing one WISHBONE bridge port among NM masters; the grant
// is held for a whole cycle. Optional stall watchdog: `define WB_ARB_TIMEOUT_EN.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int TMO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arb_if.slave       bus,
  output logic [NM-1:0] gnt_o
);

  localparam int LW = $clog2(NM);

  arb_state_e    state_r;
  logic [NM-1:0] gnt_r;
  logic [LW-1:0] last_r;
  logic [NM-1:0] req_s;
  logic [NM-1:0] win_s;
  logic [LW-1:0] win_idx_s;
  logic          sel_s;
  logic          cyc_s;
  logic          stb_raw_s;
  logic          we_s;
  logic [31:0]   adr_s;
  logic [31:0]   dat_s;
  logic [3:0]    sel_bits_s;
  logic [2:0]    cti_s;
  logic [1:0]    bte_s;
  logic          tmo_s;

  // The current owner is excluded so that it ranks behind every other requester
  assign req_s = bus.m_cyc_i & ~gnt_r;

  wb_arb_rr #(.NM(NM), .LW(LW)) u_rr (
    .req     (req_s),
    .last    (last_r),
    .win     (win_s),
    .win_idx (win_idx_s)
  );

  // Grant FSM: IDLE picks a winner; OWN holds until the owner's cyc drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= {NM{1'b0}};
      last_r  <= LW'(NM - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|req_s) begin
            gnt_r   <= win_s;
            last_r  <= win_idx_s;
            state_r <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!bus.m_cyc_i[last_r]) begin
            if (|req_s) begin
              gnt_r  <= win_s;
              last_r <= win_idx_s;
            end else begin
              gnt_r   <= {NM{1'b0}};
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          gnt_r   <= {NM{1'b0}};
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // AND-OR mux of the owner's request fields, qualified by its own cyc
  always_comb begin
    sel_s      = 1'b0;
    cyc_s      = 1'b0;
    stb_raw_s  = 1'b0;
    we_s       = 1'b0;
    adr_s      = 32'h0000_0000;
    dat_s      = 32'h0000_0000;
    sel_bits_s = 4'h0;
    cti_s      = 3'b000;
    bte_s      = 2'b00;
    for (int k = 0; k < NM; k++) begin
      sel_s      = gnt_r[k] & bus.m_cyc_i[k];
      cyc_s      = cyc_s | sel_s;
      stb_raw_s  = stb_raw_s | (sel_s & bus.m_stb_i[k]);
      we_s       = we_s | (sel_s & bus.m_we_i[k]);
      adr_s      = adr_s | ({32{sel_s}} & bus.m_adr_i[32*k +: 32]);
      dat_s      = dat_s | ({32{sel_s}} & bus.m_dat_i[32*k +: 32]);
      sel_bits_s = sel_bits_s | ({4{sel_s}} & bus.m_sel_i[4*k +: 4]);
      cti_s      = cti_s | ({3{sel_s}} & bus.m_cti_i[3*k +: 3]);
      bte_s      = bte_s | ({2{sel_s}} & bus.m_bte_i[2*k +: 2]);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = (TMO_CYC > 255) ? $clog2(TMO_CYC + 1) : 8;

  logic [TW-1:0] tmo_cnt_r;
  logic          resp_s;

  assign resp_s = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  // Fires during the TMO_CYC-th consecutive stalled strobe cycle
  assign tmo_s  = stb_raw_s & ~resp_s & (tmo_cnt_r == TW'(TMO_CYC - 1));

  // Stall counter: cleared by any response, an idle strobe, or its own expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if (!stb_raw_s || resp_s || tmo_s) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end
`else
  assign tmo_s = (TMO_CYC < 32'sd0) ? 1'b1 : 1'b0;
`endif

  assign bus.s_cyc_o = cyc_s;
  assign bus.s_stb_o = stb_raw_s & ~tmo_s;
  assign bus.s_we_o  = we_s;
  assign bus.s_adr_o = adr_s;
  assign bus.s_dat_o = dat_s;
  assign bus.s_sel_o = sel_bits_s;
  assign bus.s_cti_o = cti_s;
  assign bus.s_bte_o = bte_s;

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = gnt_r & {NM{bus.s_ack_i}};
  assign bus.m_err_o = gnt_r & {NM{bus.s_err_i | tmo_s}};
  assign bus.m_rty_o = gnt_r & {NM{bus.s_rty_i}};

  assign gnt_o = gnt_r;

endmodule

// File: tb/tb_wb_arb.sv
// Directed self-checking bench for wb_arb (NM=4, TMO_CYC=8); the timeout scenario
// adapts its expectations to WB_ARB_TIMEOUT_EN.
module tb_wb_arb;
  import wb_arb_pkg::*;

  localparam int NM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] gnt_o;
  int            tests_run = 0;
  int            tests_failed = 0;

  wb_arb_if #(.NM(NM)) bus();

  wb_arb #(.NM(NM), .TMO_CYC(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .gnt_o (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [2:0] cti, input logic [1:0] bte);
    bus.m_cyc_i[k]         = cyc;
    bus.m_stb_i[k]         = stb;
    bus.m_we_i[k]          = we;
    bus.m_adr_i[32*k +: 32] = adr;
    bus.m_dat_i[32*k +: 32] = adr ^ 32'hA5A5_0000;
    bus.m_sel_i[4*k +: 4]  = 4'hF;
    bus.m_cti_i[3*k +: 3]  = cti;
    bus.m_bte_i[2*k +: 2]  = bte;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0; bus.m_adr_i = '0;
    bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_cti_i = '0; bus.m_bte_i = '0;
    bus.s_dat_i = 32'h0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
    #12;
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_0123, WBCTI_CLASSIC, WBBTE_LINEAR);
    bus.s_ack_i = 1'b1;
    tick;
    tests_run++; if (gnt_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt: got %b expected 0000", gnt_o); end
    tests_run++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_s_out: cyc=%b stb=%b adr=%h expected 0/0/0", bus.s_cyc_o, bus.s_stb_o, bus.s_adr_o); end
    tests_run++; if (bus.m_ack_o !== 4'b0000 || bus.m_err_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_resp: ack=%b err=%b expected 0000", bus.m_ack_o, bus.m_err_o); end
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, WBCTI_CLASSIC, WBBTE_LINEAR);
    bus.s_ack_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read;
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, WBCTI_CLASSIC, WBBTE_LINEAR);
    #1;
    tests_run++; if (bus.s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL sr_latency: s_cyc_o=%b expected 0 before edge", bus.s_cyc_o); end
    tick;
    tests_run++; if (gnt_o !== 4'b0001) begin tests_failed++; $display("FAIL sr_gnt: got %b expected 0001", gnt_o); end
    tests_run++; if (bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1 || bus.s_we_o !== 1'b0) begin tests_failed++; $display("FAIL sr_ctrl: cyc=%b stb=%b we=%b expected 1/1/0", bus.s_cyc_o, bus.s_stb_o, bus.s_we_o); end
    tests_run++; if (bus.s_adr_o !== 32'h0000_0100) begin tests_failed++; $display("FAIL sr_adr: got %h expected 00000100", bus.s_adr_o); end
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hCAFE_F00D;
    #1;
    tests_run++; if (bus.m_ack_o !== 4'b0001) begin tests_failed++; $display("FAIL sr_ack: got %b expected 0001", bus.m_ack_o); end
    tests_run++; if (bus.m_dat_o !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL sr_dat: got %h expected cafef00d", bus.m_dat_o); end
    tick;
    bus.s_ack_i = 1'b0;
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, WBCTI_CLASSIC, WBBTE_LINEAR);
    tick;
    tests_run++; if (gnt_o !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL sr_release: gnt=%b cyc=%b expected 0000/0", gnt_o, bus.s_cyc_o); end
  endtask

  task automatic test_round_robin;
    int order [5];
    logic [3:0] exp_gnt;
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1'b1, 1'b1, 32'h0000_1000 + 32'(16*k), WBCTI_CLASSIC, WBBTE_LINEAR);
    tick;
    for (int n = 0; n < 5; n++) begin
      exp_gnt = 4'b0001 << order[n];
      tests_run++; if (gnt_o !== exp_gnt) begin tests_failed++; $display("FAIL rr_gnt%0d: got %b expected %b", n, gnt_o, exp_gnt); end
      tests_run++; if (bus.s_adr_o !== 32'h0000_1000 + 32'(16*order[n])) begin tests_failed++; $display("FAIL rr_adr%0d: got %h expected %h", n, bus.s_adr_o, 32'h0000_1000 + 32'(16*order[n])); end
      repeat (3) tick;
      tests_run++; if (gnt_o !== exp_gnt) begin tests_failed++; $display("FAIL rr_hold%0d: got %b expected %b", n, gnt_o, exp_gnt); end
      bus.m_cyc_i[order[n]] = 1'b0;
      if (n < 4) begin
        tick;
        bus.m_cyc_i[order[n]] = 1'b1;
      end else begin
        bus.m_cyc_i = 4'b0000;
        bus.m_stb_i = 4'b0000;
        tick;
        tests_run++; if (gnt_o !== 4'b0000) begin tests_failed++; $display("FAIL rr_idle: got %b expected 0000", gnt_o); end
      end
    end
  endtask

  task automatic test_burst_hold;
    logic [31:0] adr_seq [4];
    logic        seen1;
    adr_seq = '{32'h0000_0208, 32'h0000_020C, 32'h0000_0200, 32'h0000_0204};
    seen1 = 1'b0;
    set_master(2, 1'b1, 1'b1, 1'b0, adr_seq[0], WBCTI_INCR, WBBTE_WRAP4);
    tick;
    tests_run++; if (gnt_o !== 4'b0100) begin tests_failed++; $display("FAIL burst_gnt: got %b expected 0100", gnt_o); end
    set_master(1, 1'b1, 1'b1, 1'b1, 32'h0000_0111, WBCTI_CLASSIC, WBBTE_LINEAR);
    for (int b = 0; b < 4; b++) begin
      bus.m_adr_i[64 +: 32] = adr_seq[b];
      if (b == 3) bus.m_cti_i[6 +: 3] = WBCTI_EOB;
      bus.s_ack_i = 1'b1;
      #1;
      tests_run++; if (gnt_o !== 4'b0100 || bus.m_ack_o !== 4'b0100) begin tests_failed++; $display("FAIL burst_beat%0d: gnt=%b ack=%b expected 0100/0100", b, gnt_o, bus.m_ack_o); end
      tests_run++; if (bus.s_adr_o !== adr_seq[b] || bus.s_bte_o !== WBBTE_WRAP4) begin tests_failed++; $display("FAIL burst_fields%0d: adr=%h bte=%b expected %h/01", b, bus.s_adr_o, bus.s_bte_o, adr_seq[b]); end
      seen1 = seen1 | bus.m_ack_o[1];
      tick;
    end
    bus.s_ack_i = 1'b0;
    set_master(2, 1'b0, 1'b0, 1'b0, 32'h0, WBCTI_CLASSIC, WBBTE_LINEAR);
    #1;
    tests_run++; if (gnt_o !== 4'b0100 || seen1 !== 1'b0) begin tests_failed++; $display("FAIL burst_end: gnt=%b m1_acked=%b expected 0100/0", gnt_o, seen1); end
    tick;
    tests_run++; if (gnt_o !== 4'b0010 || bus.s_adr_o !== 32'h0000_0111) begin tests_failed++; $display("FAIL burst_handover: gnt=%b adr=%h expected 0010/00000111", gnt_o, bus.s_adr_o); end
    bus.m_cyc_i[1] = 1'b0;
    tick;
  endtask

  task automatic test_stb_gap;
    set_master(3, 1'b1, 1'b1, 1'b1, 32'h0000_0300, WBCTI_INCR, WBBTE_LINEAR);
    tick;
    tests_run++; if (gnt_o !== 4'b1000) begin tests_failed++; $display("FAIL gap_gnt: got %b expected 1000", gnt_o); end
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    bus.m_stb_i[3] = 1'b0;
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, WBCTI_CLASSIC, WBBTE_LINEAR);
    for (int c = 0; c < 3; c++) begin
      #1;
      tests_run++; if (gnt_o !== 4'b1000 || bus.s_stb_o !== 1'b0 || bus.s_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL gap_hold%0d: gnt=%b stb=%b cyc=%b expected 1000/0/1", c, gnt_o, bus.s_stb_o, bus.s_cyc_o); end
      tests_run++; if (bus.m_ack_o !== 4'b0000 || bus.m_err_o !== 4'b0000 || bus.m_rty_o !== 4'b0000) begin tests_failed++; $display("FAIL gap_resp%0d: ack=%b err=%b rty=%b expected 0000", c, bus.m_ack_o, bus.m_err_o, bus.m_rty_o); end
      tick;
    end
    bus.m_stb_i[3] = 1'b1;
    bus.s_ack_i = 1'b1;
    tick;
    bus.s_ack_i = 1'b0;
    set_master(3, 1'b0, 1'b0, 1'b0, 32'h0, WBCTI_CLASSIC, WBBTE_LINEAR);
    tick;
    tests_run++; if (gnt_o !== 4'b0001) begin tests_failed++; $display("FAIL gap_next: got %b expected 0001", gnt_o); end
    bus.m_cyc_i[0] = 1'b0;
    tick;
  endtask

  task automatic test_async_reset;
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_0510, WBCTI_CLASSIC, WBBTE_LINEAR);
    tick;
    tests_run++; if (gnt_o !== 4'b0010 || bus.s_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL ar_own: gnt=%b cyc=%b expected 0010/1", gnt_o, bus.s_cyc_o); end
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_0500, WBCTI_CLASSIC, WBBTE_LINEAR);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (gnt_o !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL ar_drop: gnt=%b cyc=%b expected 0000/0 before edge", gnt_o, bus.s_cyc_o); end
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    tests_run++; if (gnt_o !== 4'b0001) begin tests_failed++; $display("FAIL ar_first: got %b expected 0001", gnt_o); end
    bus.m_cyc_i = 4'b0000;
    bus.m_stb_i = 4'b0000;
    tick;
  endtask

  task automatic test_timeout;
    logic [3:0] exp_err;
    logic       exp_stb;
    set_master(2, 1'b1, 1'b1, 1'b0, 32'h0000_0600, WBCTI_CLASSIC, WBBTE_LINEAR);
    tick;
    for (int c = 1; c <= 12; c++) begin
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = (c == 8) ? 4'b0100 : 4'b0000;
      exp_stb = (c == 8) ? 1'b0 : 1'b1;
`else
      exp_err = 4'b0000;
      exp_stb = 1'b1;
`endif
      tests_run++; if (bus.m_err_o !== exp_err || bus.s_stb_o !== exp_stb) begin tests_failed++; $display("FAIL tmo_cyc%0d: err=%b stb=%b expected %b/%b", c, bus.m_err_o, bus.s_stb_o, exp_err, exp_stb); end
      tick;
    end
    tests_run++; if (gnt_o !== 4'b0100) begin tests_failed++; $display("FAIL tmo_keep: got %b expected 0100", gnt_o); end
    set_master(2, 1'b0, 1'b0, 1'b0, 32'h0, WBCTI_CLASSIC, WBBTE_LINEAR);
    tick;
    tests_run++; if (gnt_o !== 4'b0000) begin tests_failed++; $display("FAIL tmo_release: got %b expected 0000", gnt_o); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_burst_hold;
    test_stb_gap;
    test_async_reset;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
